// File: rtl/pc_pkg.sv
// Shared constants and next-PC select type for the program-counter sequencer.
package pc_pkg;

    localparam int unsigned PC_WIDTH        = 32;
    localparam int unsigned PC_STEP         = 4;
    localparam logic [31:0] PC_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] PC_EXC_VECTOR   = 32'h0000_0180;
    localparam int unsigned PC_RAS_DEPTH    = 4;

    typedef enum logic [2:0] {
        EXC,
        HOLD,
        BRANCH,
        CALL,
        RET,
        SEQ
    } pc_sel_e;

endpackage

// File: rtl/return_address_stack.sv
// Circular return-address stack: push at top+1, pop at top, oldest entry is
// overwritten when full and the sticky overflow flag is raised.
module return_address_stack #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] data,
    output logic             empty,
    output logic             full,
    output logic             overflow
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] top_q, top_d, top_inc;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;

    assign top_inc  = top_q + PTR_W'(1);
    assign data     = mem_q[top_q];
    assign empty    = (count_q == '0);
    assign full     = (count_q == CNT_W'(DEPTH));
    assign overflow = overflow_q;

    always_comb begin
        top_d      = top_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (flush) begin
            count_d = '0;
        end else if (push) begin
            top_d = top_inc;
            // A full stack keeps its count; the slot at top+1 is the oldest entry.
            if (full) begin
                overflow_d = 1'b1;
            end else begin
                count_d = count_q + CNT_W'(1);
            end
        end else if (pop && !empty) begin
            top_d   = top_q - PTR_W'(1);
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            top_q      <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            top_q      <= top_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem_q[top_inc] <= push_data;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer with prioritised redirects. The return address
// stack is built in only when PC_SEQUENCER_RAS_EN is defined.
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int unsigned      WIDTH        = PC_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(PC_RESET_VECTOR),
    parameter int unsigned      STEP         = PC_STEP,
    parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(PC_EXC_VECTOR),
    parameter int unsigned      RAS_DEPTH    = PC_RAS_DEPTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             hazard,
    input  logic             exception,
    input  logic             branchTaken,
    input  logic [WIDTH-1:0] branchTarget,
    input  logic             callValid,
    input  logic [WIDTH-1:0] callTarget,
    input  logic             returnValid,
    input  logic [WIDTH-1:0] returnTarget,
    output logic [WIDTH-1:0] programCounterOutput,
    output logic [WIDTH-1:0] programCounterPlusStep,
    output logic             rasEmpty,
    output logic             rasFull,
    output logic             rasOverflow
);

    pc_sel_e          sel;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] pc_plus;
    logic [WIDTH-1:0] ras_top;
    logic             ras_empty, ras_full, ras_overflow;

    assign pc_plus = pc_q + WIDTH'(STEP);

`ifdef PC_SEQUENCER_RAS_EN
    return_address_stack #(
        .WIDTH (WIDTH),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst_n     (reset),
        .push      (sel == CALL),
        .pop       (sel == RET),
        .flush     (sel == EXC),
        .push_data (pc_plus),
        .data      (ras_top),
        .empty     (ras_empty),
        .full      (ras_full),
        .overflow  (ras_overflow)
    );
`else
    assign ras_top      = '0;
    assign ras_empty    = 1'b1;
    // Depth is always >= 2, so this folds to a constant 0.
    assign ras_full     = (RAS_DEPTH == 0);
    assign ras_overflow = 1'b0;
`endif

    always_comb begin
        sel = SEQ;
        if (exception)        sel = EXC;
        else if (hazard)      sel = HOLD;
        else if (branchTaken) sel = BRANCH;
        else if (callValid)   sel = CALL;
        else if (returnValid) sel = RET;
    end

    always_comb begin
        pc_d = pc_plus;
        case (sel)
            EXC:     pc_d = EXC_VECTOR;
            HOLD:    pc_d = pc_q;
            BRANCH:  pc_d = branchTarget;
            CALL:    pc_d = callTarget;
            RET:     pc_d = ras_empty ? returnTarget : ras_top;
            default: pc_d = pc_plus;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q <= RESET_VECTOR;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign programCounterOutput   = pc_q;
    assign programCounterPlusStep = pc_plus;
    assign rasEmpty               = ras_empty;
    assign rasFull                = ras_full;
    assign rasOverflow            = ras_overflow;

endmodule
